// File: rtl/ir_fetch.sv
// Instruction-register fetch stage: latches an opcode on a sync read, gathers its
// operand bytes, and hands the complete bundle to execute over valid/ready.
module ir_fetch #(
  parameter int                DATA_W   = 8,
  parameter int                MAX_OPS  = 2,
  parameter int                LEN_W    = $clog2(MAX_OPS + 1),
  parameter logic [DATA_W-1:0] IR_RESET = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data,
  input  logic                        data_en,
  input  logic                        sync,
  input  logic [LEN_W-1:0]            op_len,
  output logic [DATA_W-1:0]           ir,
  output logic [MAX_OPS*DATA_W-1:0]   operand,
  output logic [LEN_W-1:0]            ops_cnt,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic                        overrun,
  output logic                        abort
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPER,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [DATA_W-1:0]           ir_q, ir_d;
  logic [MAX_OPS*DATA_W-1:0]   operand_q, operand_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic                        valid_q, valid_d;
  logic                        ovr_q, ovr_d;
  logic                        abt_q, abt_d;

  logic                        fetch;
  logic                        op_rd;
  logic [LEN_W-1:0]            eff_len;
  logic                        len_met;
  logic                        last_op;
  logic                        load;

  assign fetch = data_en & sync;
  assign op_rd = data_en & ~sync;

  always_comb begin
    eff_len = (op_len > LEN_W'(MAX_OPS)) ? LEN_W'(MAX_OPS) : op_len;
  end

  // >= rather than == keeps the count bounded if op_len shrinks mid-collection
  assign len_met = (cnt_q >= eff_len);
  assign last_op = ((cnt_q + LEN_W'(1)) == eff_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fetch) state_d = S_OPER;
      end
      S_OPER: begin
        if (fetch)                  state_d = S_OPER;
        else if (len_met)           state_d = S_DONE;
        else if (op_rd && last_op)  state_d = S_DONE;
      end
      S_DONE: begin
        if (inst_ready) state_d = fetch ? S_OPER : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ir_d      = ir_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    ovr_d     = 1'b0;
    abt_d     = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        load = fetch;
      end
      S_OPER: begin
        if (fetch) begin
          load  = 1'b1;
          abt_d = 1'b1;
        end else if (!len_met && op_rd) begin
          for (int unsigned k = 0; k < MAX_OPS; k++) begin
            if (LEN_W'(k) == cnt_q) operand_d[k*DATA_W +: DATA_W] = data;
          end
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_DONE: begin
        if (inst_ready) load  = fetch;
        else            ovr_d = fetch;
      end
      default: load = 1'b0;
    endcase
    if (load) begin
      ir_d      = data;
      operand_d = '0;
      cnt_d     = '0;
    end
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q      <= IR_RESET;
      operand_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      abt_q     <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      abt_q     <= abt_d;
    end
  end

  assign ir         = ir_q;
  assign operand    = operand_q;
  assign ops_cnt    = cnt_q;
  assign inst_valid = valid_q;
  assign overrun    = ovr_q;
  assign abort      = abt_q;

endmodule

// File: tb/tb_ir_fetch.sv
// Bench for ir_fetch: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the fetch stage.
module tb_ir_fetch;

  localparam int DATA_W  = 8;
  localparam int MAX_OPS = 2;
  localparam int LEN_W   = $clog2(MAX_OPS + 1);

  logic                      clk = 1'b0;
  logic                      rst;
  logic [DATA_W-1:0]         data;
  logic                      data_en;
  logic                      sync;
  logic [LEN_W-1:0]          op_len;
  logic [DATA_W-1:0]         ir;
  logic [MAX_OPS*DATA_W-1:0] operand;
  logic [LEN_W-1:0]          ops_cnt;
  logic                      inst_valid;
  logic                      inst_ready;
  logic                      overrun;
  logic                      abort;

  int n_cmp = 0;
  int n_bad = 0;

  ir_fetch #(.DATA_W(DATA_W), .MAX_OPS(MAX_OPS), .LEN_W(LEN_W), .IR_RESET(8'h00)) dut (
    .clk(clk), .rst(rst), .data(data), .data_en(data_en), .sync(sync),
    .op_len(op_len), .ir(ir), .operand(operand), .ops_cnt(ops_cnt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .overrun(overrun), .abort(abort)
  );

  always #5 clk = ~clk;

  // Model: an instruction is either being collected, pending hand-off, or absent.
  logic [7:0] m_ir = 8'h00;
  logic [7:0] m_ops[$];
  bit         m_collect = 0;
  bit         m_pending = 0;
  bit         m_ovr = 0;
  bit         m_abt = 0;

  function automatic logic [15:0] m_operand();
    logic [15:0] v = '0;
    for (int k = 0; k < MAX_OPS; k++)
      if (k < m_ops.size()) v[k*8 +: 8] = m_ops[k];
    return v;
  endfunction

  task automatic m_begin(input logic [7:0] opc);
    m_ir = opc;
    m_ops.delete();
    m_collect = 1;
  endtask

  task automatic model_step();
    bit fetch = data_en & sync;
    bit rd    = data_en & ~sync;
    int need  = (int'(op_len) > MAX_OPS) ? MAX_OPS : int'(op_len);
    m_ovr = 0;
    m_abt = 0;
    if (rst) begin
      m_ir = 8'h00; m_ops.delete(); m_collect = 0; m_pending = 0;
    end else if (m_pending) begin
      if (inst_ready) begin
        m_pending = 0;
        if (fetch) m_begin(data);
      end else if (fetch) begin
        m_ovr = 1;
      end
    end else if (m_collect) begin
      if (fetch) begin
        m_begin(data);
        m_abt = 1;
      end else if (m_ops.size() >= need) begin
        m_collect = 0; m_pending = 1;
      end else if (rd) begin
        m_ops.push_back(data);
        if (m_ops.size() == need) begin
          m_collect = 0; m_pending = 1;
        end
      end
    end else if (fetch) begin
      m_begin(data);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit en, input bit sy, input logic [7:0] d,
                     input logic [LEN_W-1:0] len, input bit rdy);
    rst = r; data_en = en; sync = sy; data = d; op_len = len; inst_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    chk("ir",         32'(ir),         32'(m_ir));
    chk("operand",    32'(operand),    32'(m_operand()));
    chk("ops_cnt",    32'(ops_cnt),    32'(m_ops.size()));
    chk("inst_valid", 32'(inst_valid), 32'(m_pending));
    chk("overrun",    32'(overrun),    32'(m_ovr));
    chk("abort",      32'(abort),      32'(m_abt));
  endtask

  initial begin
    rst = 1'b1; data = '0; data_en = 1'b0; sync = 1'b0; op_len = '0; inst_ready = 1'b0;
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(1, 0, 0, 8'h00, 0, 0);
    chk("reset_ir", 32'(ir), 32'h00);

    // Reset while collecting operands
    cyc(0, 1, 1, 8'hAD, 2, 0);
    cyc(0, 1, 0, 8'h77, 2, 0);
    cyc(1, 0, 0, 8'h00, 2, 0);
    cyc(1, 1, 1, 8'h55, 2, 1);
    chk("rst_oper_ir", 32'(ir), 32'h00);
    chk("rst_oper_operand", 32'(operand), 32'h0);
    chk("rst_oper_valid", 32'(inst_valid), 32'h0);
    chk("rst_oper_pulses", 32'({overrun, abort}), 32'h0);

    // Implied instruction
    cyc(0, 1, 1, 8'hEA, 0, 0);
    chk("nop_ir", 32'(ir), 32'hEA);
    chk("nop_valid_early", 32'(inst_valid), 32'h0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("nop_valid", 32'(inst_valid), 32'h1);
    cyc(0, 0, 0, 8'h00, 0, 1);
    chk("nop_released", 32'(inst_valid), 32'h0);

    // Absolute instruction with a gap between operands
    cyc(0, 1, 1, 8'hAD, 2, 0);
    cyc(0, 1, 0, 8'h34, 2, 0);
    cyc(0, 0, 0, 8'h00, 2, 0);
    cyc(0, 1, 0, 8'h12, 2, 0);
    chk("abs_operand", 32'(operand), 32'h1234);
    chk("abs_cnt", 32'(ops_cnt), 32'h2);
    chk("abs_valid", 32'(inst_valid), 32'h1);
    cyc(0, 0, 0, 8'h00, 2, 0);
    cyc(0, 1, 0, 8'hFF, 2, 0);
    chk("done_rd_ignored", 32'(operand), 32'h1234);
    chk("abs_valid_held", 32'(inst_valid), 32'h1);

    // Back-to-back hand-off with a new fetch
    cyc(0, 1, 1, 8'hA9, 2, 1);
    chk("b2b_no_overrun", 32'(overrun), 32'h0);
    chk("b2b_ir", 32'(ir), 32'hA9);
    chk("b2b_valid_drop", 32'(inst_valid), 32'h0);
    cyc(0, 1, 0, 8'h05, 1, 0);
    chk("b2b_operand", 32'(operand), 32'h0005);
    chk("b2b_valid", 32'(inst_valid), 32'h1);

    // Overrun while pending
    cyc(0, 1, 1, 8'h60, 1, 0);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_ir_kept", 32'(ir), 32'hA9);
    cyc(0, 0, 0, 8'h00, 1, 0);
    chk("ovr_one_cycle", 32'(overrun), 32'h0);
    cyc(0, 0, 0, 8'h00, 1, 1);

    // Abort mid collection
    cyc(0, 1, 1, 8'h20, 2, 0);
    cyc(0, 1, 0, 8'h11, 2, 0);
    cyc(0, 1, 1, 8'h4C, 2, 0);
    chk("abt_pulse", 32'(abort), 32'h1);
    chk("abt_cnt", 32'(ops_cnt), 32'h0);
    chk("abt_ir", 32'(ir), 32'h4C);
    cyc(0, 1, 0, 8'h01, 2, 0);
    chk("abt_one_cycle", 32'(abort), 32'h0);
    cyc(0, 1, 0, 8'h02, 2, 0);
    cyc(0, 0, 0, 8'h00, 2, 1);
    cyc(0, 1, 0, 8'h99, 2, 0);
    chk("idle_rd_ignored", 32'(operand), 32'h0201);

    // Over-long length clamps to MAX_OPS
    cyc(0, 1, 1, 8'h6D, 3, 0);
    cyc(0, 1, 0, 8'hAA, 3, 0);
    cyc(0, 1, 0, 8'hBB, 3, 0);
    chk("clamp_valid", 32'(inst_valid), 32'h1);
    chk("clamp_cnt", 32'(ops_cnt), 32'h2);
    chk("clamp_operand", 32'(operand), 32'hBBAA);
    cyc(0, 0, 0, 8'h00, 3, 1);

    // Random traffic; the bench's length decoder derives op_len from the opcode
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      bit en, sy, rdy, r;
      d   = 8'($urandom);
      en  = ($urandom_range(0, 99) < 60);
      sy  = ($urandom_range(0, 99) < 25);
      rdy = ($urandom_range(0, 99) < 50);
      r   = ($urandom_range(0, 99) < 2);
      cyc(r, en, sy, d, m_ir[1:0], rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
